// File: rtl/mix_sequencer_pkg.sv
// Shared constants and FSM encoding for the time-multiplexed voice mixer.
package mix_sequencer_pkg;

  localparam int NUM_VOICES = 13;
  localparam int WAVE_W     = 10;
  localparam int SUM_W      = 14;
  localparam int SEL_W      = 4;

  // Index of the final voice in a frame; reaching it closes the frame.
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_VOICES - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_ZERO = SEL_W'(0);
  localparam logic [SUM_W-1:0] SUM_ZERO = SUM_W'(0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Zero-extend a voice sample to accumulator width.
  function automatic logic [SUM_W-1:0] widen_wave(input logic [WAVE_W-1:0] w);
    return {{(SUM_W - WAVE_W){1'b0}}, w};
  endfunction

endpackage

// File: rtl/mix_sequencer.sv
// Walks all voices once per sample tick, summing enabled voices into one
// mixed sample reported with a single-cycle valid pulse.
module mix_sequencer
  import mix_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick_i,
  input  logic [NUM_VOICES-1:0] voice_en_i,
  output logic [SEL_W-1:0]      voice_sel_o,
  input  logic [WAVE_W-1:0]     wave_in_i,
  output logic [SUM_W-1:0]      mix_out_o,
  output logic                  mix_valid_o,
  output logic [SEL_W-1:0]      active_count_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [SUM_W-1:0]        acc_q, acc_d;
  logic [SEL_W-1:0]        cnt_q, cnt_d;
  logic [NUM_VOICES-1:0]   mask_q, mask_d;
  logic [SUM_W-1:0]        mix_out_q, mix_out_d;
  logic [SEL_W-1:0]        active_count_q, active_count_d;
  logic                    mix_valid_q, mix_valid_d;
  logic                    overrun_q, overrun_d;

  logic                    voice_on_s;
  logic                    last_s;
  logic [SUM_W-1:0]        acc_add_s;
  logic [SEL_W-1:0]        cnt_add_s;

  // Per-cycle contribution of the voice currently on the mux.
  always_comb begin
    voice_on_s = mask_q[idx_q];
    last_s     = (idx_q == LAST_IDX);
    if (voice_on_s) begin
      acc_add_s = acc_q + widen_wave(wave_in_i);
      cnt_add_s = cnt_q + SEL_ONE;
    end else begin
      acc_add_s = acc_q;
      cnt_add_s = cnt_q;
    end
  end

  // State register: async clear, otherwise follows next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a tick starts a frame, the last voice ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick_i) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath/output next values: index walk, accumulation, frame result.
  always_comb begin
    idx_d          = idx_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    mask_d         = mask_q;
    mix_out_d      = mix_out_q;
    active_count_d = active_count_q;
    mix_valid_d    = 1'b0;
    overrun_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick_i) begin
          // Mask is captured once so mid-frame enable changes are ignored.
          mask_d = voice_en_i;
          acc_d  = SUM_ZERO;
          cnt_d  = SEL_ZERO;
          idx_d  = SEL_ZERO;
        end else begin
          idx_d  = SEL_ZERO;
        end
      end
      ST_ACCUM: begin
        // A tick during a frame is dropped and flagged one cycle later.
        overrun_d = sample_tick_i;
        if (last_s) begin
          mix_out_d      = acc_add_s;
          active_count_d = cnt_add_s;
          mix_valid_d    = 1'b1;
          acc_d          = acc_add_s;
          cnt_d          = cnt_add_s;
          idx_d          = SEL_ZERO;
        end else begin
          acc_d = acc_add_s;
          cnt_d = cnt_add_s;
          idx_d = idx_q + SEL_ONE;
        end
      end
      default: begin
        idx_d = SEL_ZERO;
      end
    endcase
  end

  // Datapath and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q          <= SEL_ZERO;
      acc_q          <= SUM_ZERO;
      cnt_q          <= SEL_ZERO;
      mask_q         <= {NUM_VOICES{1'b0}};
      mix_out_q      <= SUM_ZERO;
      active_count_q <= SEL_ZERO;
      mix_valid_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      mask_q         <= mask_d;
      mix_out_q      <= mix_out_d;
      active_count_q <= active_count_d;
      mix_valid_q    <= mix_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  // idx_q is held at zero outside a frame, so it drives the mux directly.
  assign voice_sel_o    = idx_q;
  assign busy_o         = (state_q == ST_ACCUM);
  assign mix_out_o      = mix_out_q;
  assign active_count_o = active_count_q;
  assign mix_valid_o    = mix_valid_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_mix_sequencer.sv
// Directed bench for mix_sequencer: table of frames plus hand-written
// sequences for overrun, mid-frame reset and back-to-back ticks.
module tb_mix_sequencer;

  logic        clk;
  logic        rst_n;
  logic        sample_tick;
  logic [12:0] voice_en;
  logic [3:0]  voice_sel;
  logic [9:0]  wave_in;
  logic [13:0] mix_out;
  logic        mix_valid;
  logic [3:0]  active_count;
  logic        busy;
  logic        overrun;

  // Wave source model: constant level or voice_sel*10+1.
  logic        wave_mode;
  logic [9:0]  wave_const;

  int n_cmp = 0;
  int n_err = 0;

  mix_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_tick_i  (sample_tick),
    .voice_en_i     (voice_en),
    .voice_sel_o    (voice_sel),
    .wave_in_i      (wave_in),
    .mix_out_o      (mix_out),
    .mix_valid_o    (mix_valid),
    .active_count_o (active_count),
    .busy_o         (busy),
    .overrun_o      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (wave_mode) wave_in = 10'(int'(voice_sel) * 10 + 1);
    else           wave_in = wave_const;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".voice_sel"},    32'(voice_sel),    0);
    check({name, ".mix_out"},      32'(mix_out),      0);
    check({name, ".active_count"}, 32'(active_count), 0);
    check({name, ".mix_valid"},    32'(mix_valid),    0);
    check({name, ".busy"},         32'(busy),         0);
    check({name, ".overrun"},      32'(overrun),      0);
  endtask

  // Runs one frame from a negedge in IDLE; ends one negedge after mix_valid.
  task automatic run_frame(input logic [12:0] en, input logic [13:0] exp_mix,
                           input logic [3:0] exp_cnt);
    voice_en    = en;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      check("frame.busy",      32'(busy),      1);
      check("frame.voice_sel", 32'(voice_sel), 32'(k - 1));
      check("frame.mix_valid", 32'(mix_valid), 0);
      check("frame.overrun",   32'(overrun),   0);
      @(negedge clk);
    end
    check("frame.valid_pulse", 32'(mix_valid),    1);
    check("frame.busy_done",   32'(busy),         0);
    check("frame.sel_idle",    32'(voice_sel),    0);
    check("frame.mix_out",     32'(mix_out),      32'(exp_mix));
    check("frame.active_cnt",  32'(active_count), 32'(exp_cnt));
    @(negedge clk);
    check("frame.valid_low",   32'(mix_valid),    0);
    check("frame.mix_hold",    32'(mix_out),      32'(exp_mix));
    check("frame.cnt_hold",    32'(active_count), 32'(exp_cnt));
  endtask

  typedef struct {
    logic [12:0] en;
    logic        mode;
    logic [9:0]  wconst;
    logic [13:0] exp_mix;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int ov_pulses;
    int mv_pulses;
    int mv_at;

    // Expected sums worked by hand: mode 1 gives voice i the value 10*i+1.
    vecs[0] = '{13'h1FFF, 1'b0, 10'd1023, 14'd13299, 4'd13};
    vecs[1] = '{13'h0005, 1'b1, 10'd0,    14'd22,    4'd2};   // 1 + 21
    vecs[2] = '{13'h0000, 1'b0, 10'd1023, 14'd0,     4'd0};
    vecs[3] = '{13'h1000, 1'b1, 10'd0,    14'd121,   4'd1};
    vecs[4] = '{13'h0AAA, 1'b1, 10'd0,    14'd366,   4'd6};   // 11+31+51+71+91+111
    vecs[5] = '{13'h1555, 1'b1, 10'd0,    14'd427,   4'd7};   // 1+21+...+121

    rst_n       = 1'b0;
    sample_tick = 1'b0;
    voice_en    = 13'h0000;
    wave_mode   = 1'b0;
    wave_const  = 10'd1023;

    // Reset state, then idle with no tick: no valid ever.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle.mix_valid", 32'(mix_valid), 0);
      check("idle.busy",      32'(busy),      0);
    end

    // Table of full frames.
    for (int v = 0; v < 6; v++) begin
      wave_mode  = vecs[v].mode;
      wave_const = vecs[v].wconst;
      run_frame(vecs[v].en, vecs[v].exp_mix, vecs[v].exp_cnt);
    end

    // Overrun: ticks mid-frame and in the last ACCUM cycle, mask cleared at cycle 3.
    wave_mode   = 1'b0;
    wave_const  = 10'd1023;
    voice_en    = 13'h1FFF;
    sample_tick = 1'b1;
    ov_pulses   = 0;
    mv_pulses   = 0;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      check("ovr.overrun", 32'(overrun), 32'((k == 6) || (k == 14)));
      check("ovr.busy",    32'(busy),    32'(k <= 13));
      if (overrun)   ov_pulses++;
      if (mix_valid) mv_pulses++;
      if (k == 14) begin
        check("ovr.mix_out",    32'(mix_out),      13299);
        check("ovr.active_cnt", 32'(active_count), 13);
      end
      if (k == 3) voice_en = 13'h0000;
      sample_tick = (k == 5) || (k == 13);
      @(negedge clk);
    end
    sample_tick = 1'b0;
    check("ovr.pulse_count",  32'(ov_pulses), 2);
    check("ovr.valid_count",  32'(mv_pulses), 1);

    // Reset at cycle 7 of a frame: immediate clear, no valid afterwards.
    voice_en    = 13'h1FFF;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (6) @(negedge clk);
    check("rst.busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst_n     = 1'b1;
    mv_pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (mix_valid) mv_pulses++;
      check("rst.busy_after", 32'(busy), 0);
    end
    check("rst.no_valid", 32'(mv_pulses), 0);
    check("rst.mix_zero", 32'(mix_out),   0);
    run_frame(13'h1FFF, 14'd13299, 4'd13);

    // Back-to-back: tick in the mix_valid cycle is accepted.
    voice_en    = 13'h1FFF;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (13) @(negedge clk);
    check("b2b.first_valid", 32'(mix_valid), 1);
    check("b2b.first_mix",   32'(mix_out),   13299);
    wave_mode   = 1'b1;
    voice_en    = 13'h0005;
    sample_tick = 1'b1;
    mv_at       = -1;
    ov_pulses   = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      sample_tick = 1'b0;
      if (overrun) ov_pulses++;
      if (mix_valid && mv_at < 0) mv_at = k;
    end
    check("b2b.no_overrun",   32'(ov_pulses), 0);
    check("b2b.valid_delay",  32'(mv_at),     14);
    check("b2b.second_mix",   32'(mix_out),   22);
    check("b2b.second_cnt",   32'(active_count), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
